// File: rtl/act_pkg.sv
// act_pkg: shared definitions for the activation stage.
//   - activation mode encodings carried with each transfer
//   - saturation bound helpers, parameterised by output word width
package act_pkg;

  localparam logic [1:0] MODE_LINEAR = 2'd0;
  localparam logic [1:0] MODE_RELU   = 2'd1;
  localparam logic [1:0] MODE_LEAKY  = 2'd2;
  localparam logic [1:0] MODE_CLIP   = 2'd3;

  // Largest positive value of a dw-bit signed word (0x7F..F), zero-extended.
  function automatic logic [63:0] sat_max(input int unsigned dw);
    return (64'd1 << (dw - 1)) - 64'd1;
  endfunction

  // Most negative value of a dw-bit signed word (0x80..0), zero-extended.
  function automatic logic [63:0] sat_min(input int unsigned dw);
    return 64'd1 << (dw - 1);
  endfunction

endpackage

// File: rtl/act_lane.sv
// act_lane: one lane of the activation datapath, two register stages.
//   clk, reset      : clock, synchronous active-high reset
//   en1             : load stage 1 from x/mode/clip_max
//   en2             : load stage 2 (result registers) from stage 1
//   x               : signed double-width accumulator value
//   mode, clip_max  : per-transfer activation controls
//   res, sat        : registered activation result and saturation flag
module act_lane
  import act_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 16,
  parameter int unsigned INTEGER_WIDTH = 1,
  parameter int unsigned LEAK_SHIFT    = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      en1,
  input  logic                      en2,
  input  logic [2*DATA_WIDTH-1:0]   x,
  input  logic [1:0]                mode,
  input  logic [DATA_WIDTH-1:0]     clip_max,
  output logic [DATA_WIDTH-1:0]     res,
  output logic                      sat
);

  localparam int unsigned DW = DATA_WIDTH;
  localparam int unsigned XW = 2 * DATA_WIDTH;
  localparam int unsigned TW = INTEGER_WIDTH + 1;
  localparam logic [DW-1:0] MAX_V = DW'(sat_max(DW));
  localparam logic [DW-1:0] MIN_V = DW'(sat_min(DW));

  // Stage 1 state
  logic          pos_ovf_q, pos_ovf_d;
  logic          neg_ovf_q, neg_ovf_d;
  logic          x_pos_q,   x_pos_d;
  logic [DW-1:0] slice_q,   slice_d;
  logic [1:0]    mode_q,    mode_d;
  logic [DW-1:0] clip_q,    clip_d;

  // Stage 2 state
  logic [DW-1:0] res_q, res_d;
  logic          sat_q, sat_d;

  logic signed [XW-1:0] src;
  logic [TW-1:0]        top;
  logic                 x_pos;
  logic [DW-1:0]        sat_v;
  logic                 sat_hit;
  logic [DW-1:0]        r;
  logic                 f;

  // Stage 1: pick the value to saturate (leaky shift for non-positive inputs) and classify it.
  always_comb begin
    x_pos = !x[XW-1] && (|x);
    if ((mode == MODE_LEAKY) && !x_pos) begin
      src = $signed(x) >>> LEAK_SHIFT;
    end else begin
      src = $signed(x);
    end
    top = src[XW-1 -: TW];

    pos_ovf_d = pos_ovf_q;
    neg_ovf_d = neg_ovf_q;
    x_pos_d   = x_pos_q;
    slice_d   = slice_q;
    mode_d    = mode_q;
    clip_d    = clip_q;
    if (en1) begin
      pos_ovf_d = !src[XW-1] && (top != '0);
      neg_ovf_d =  src[XW-1] && (top != '1);
      x_pos_d   = x_pos;
      // Output word is the slice just below the integer/sign guard bits.
      slice_d   = DW'(src >>> (DW - INTEGER_WIDTH));
      mode_d    = mode;
      clip_d    = clip_max;
    end
  end

  // Stage 2: final mode select and clip compare.
  always_comb begin
    sat_v   = pos_ovf_q ? MAX_V : (neg_ovf_q ? MIN_V : slice_q);
    sat_hit = pos_ovf_q || neg_ovf_q;
    r       = sat_v;
    f       = sat_hit;
    case (mode_q)
      MODE_RELU, MODE_CLIP: begin
        // Zeroing a non-positive input is not counted as saturation.
        if (!x_pos_q) begin
          r = '0;
          f = 1'b0;
        end
        if ((mode_q == MODE_CLIP) && (r > clip_q)) begin
          r = clip_q;
          f = 1'b1;
        end
      end
      default: begin
        r = sat_v;
        f = sat_hit;
      end
    endcase

    res_d = res_q;
    sat_d = sat_q;
    if (en2) begin
      res_d = r;
      sat_d = f;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pos_ovf_q <= 1'b0;
      neg_ovf_q <= 1'b0;
      x_pos_q   <= 1'b0;
      slice_q   <= '0;
      mode_q    <= MODE_LINEAR;
      clip_q    <= '0;
      res_q     <= '0;
      sat_q     <= 1'b0;
    end else begin
      pos_ovf_q <= pos_ovf_d;
      neg_ovf_q <= neg_ovf_d;
      x_pos_q   <= x_pos_d;
      slice_q   <= slice_d;
      mode_q    <= mode_d;
      clip_q    <= clip_d;
      res_q     <= res_d;
      sat_q     <= sat_d;
    end
  end

  assign res = res_q;
  assign sat = sat_q;

endmodule

// File: rtl/act_unit.sv
// act_unit: multi-lane activation stage, 2-stage valid/ready pipeline.
//   clk, reset            : clock, synchronous active-high reset
//   mode, clip_max        : activation controls, captured with each accepted input
//   in_valid/in_ready     : input handshake; in_data packs NUM_CH signed 2*DATA_WIDTH lanes
//   out_valid/out_ready   : output handshake; out_data packs NUM_CH signed DATA_WIDTH lanes
//   out_sat               : per-lane saturation flags, qualified by out_valid
//   sat_count, clr_stats  : saturating count of flagged lanes on output transfers, and its clear
module act_unit
  import act_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 16,
  parameter int unsigned INTEGER_WIDTH = 1,
  parameter int unsigned NUM_CH        = 4,
  parameter int unsigned LEAK_SHIFT    = 3,
  parameter int unsigned CNT_W         = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [1:0]                       mode,
  input  logic [DATA_WIDTH-1:0]            clip_max,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [NUM_CH*2*DATA_WIDTH-1:0]   in_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [NUM_CH*DATA_WIDTH-1:0]     out_data,
  output logic [NUM_CH-1:0]                out_sat,
  output logic [CNT_W-1:0]                 sat_count,
  input  logic                             clr_stats
);

  localparam int unsigned XW = 2 * DATA_WIDTH;
  localparam int unsigned DW = DATA_WIDTH;
  localparam int unsigned SW = CNT_W + 1;

  logic             s1_valid_q, s1_valid_d;
  logic             s2_valid_q, s2_valid_d;
  logic [CNT_W-1:0] sat_count_q, sat_count_d;

  logic             s1_adv;
  logic             accept;
  logic             out_fire;
  logic             s2_load;
  logic [SW-1:0]    sum;

  // Stage 2 is free when empty or draining this cycle; stage 1 follows it.
  assign s1_adv   = !s2_valid_q || out_ready;
  assign in_ready = !s1_valid_q || s1_adv;
  assign accept   = in_valid && in_ready;
  assign s2_load  = s1_adv && s1_valid_q;
  assign out_fire = s2_valid_q && out_ready;

  // Stage valids.
  always_comb begin
    s1_valid_d = in_ready ? accept : s1_valid_q;
    s2_valid_d = s1_adv ? s1_valid_q : s2_valid_q;
  end

  // Saturation event counter: sticks at all-ones, clear has priority.
  always_comb begin
    sum = SW'(sat_count_q);
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      sum = sum + SW'(out_sat[k]);
    end
    sat_count_d = sat_count_q;
    if (clr_stats) begin
      sat_count_d = '0;
    end else if (out_fire) begin
      sat_count_d = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      sat_count_q <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s2_valid_q  <= s2_valid_d;
      sat_count_q <= sat_count_d;
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
    act_lane #(
      .DATA_WIDTH    (DATA_WIDTH),
      .INTEGER_WIDTH (INTEGER_WIDTH),
      .LEAK_SHIFT    (LEAK_SHIFT)
    ) u_lane (
      .clk      (clk),
      .reset    (reset),
      .en1      (accept),
      .en2      (s2_load),
      .x        (in_data[k*XW +: XW]),
      .mode     (mode),
      .clip_max (clip_max),
      .res      (out_data[k*DW +: DW]),
      .sat      (out_sat[k])
    );
  end

  assign out_valid = s2_valid_q;
  assign sat_count = sat_count_q;

endmodule
